// File: rtl/sparrow_redirect_ctrl.sv
// rtl/sparrow_redirect_ctrl.sv - mispredict/trap redirect sequencer with IF/ID flush drain (perf counters: SPARROW_REDIRECT_PERF_EN)
module sparrow_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_is_branch,
    input  logic        i_ex_is_jump,
    input  logic        i_ex_branch_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_target,
    input  logic        i_trap_valid,
    input  logic [31:0] i_trap_target,
    input  logic        i_fetch_ready,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    output logic        o_flush_if,
    output logic        o_flush_id,
    output logic        o_misalign_trap,
    output logic [31:0] o_mispredict_cnt,
    output logic [31:0] o_branch_cnt
);

    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  drain_q, drain_d;
    logic        misalign_q, misalign_d;
    logic [1:0]  rst_sync_q;
    logic        rst_n_int;

    logic        eval;
    logic        actual_taken;
    logic        misaligned;
    logic        mispredict;
    logic        branch_redirect;
    logic [31:0] fix_pc;

    // Assert asynchronously, release two clocks after i_rst_n rises.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    assign eval            = (state_q == IDLE) && i_ex_valid && (i_ex_is_branch || i_ex_is_jump);
    assign actual_taken    = i_ex_is_jump || i_ex_branch_taken;
    assign misaligned      = actual_taken && (i_ex_target[1:0] != 2'b00);
    assign mispredict      = (actual_taken != i_ex_pred_taken) ||
                             (actual_taken && (i_ex_target != i_ex_pred_target));
    assign fix_pc          = actual_taken ? i_ex_target : i_ex_pc + 32'd4;
    assign branch_redirect = eval && !i_trap_valid && !misaligned && mispredict;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drain_d    = drain_q;
        misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_trap_valid) begin
                    state_d = REDIRECT;
                    pc_d    = i_trap_target;
                end else if (eval && misaligned) begin
                    misalign_d = 1'b1;
                end else if (branch_redirect) begin
                    state_d = REDIRECT;
                    pc_d    = fix_pc;
                end
            end
            REDIRECT: begin
                // A late trap must never let fetch accept the stale PC.
                if (i_trap_valid) begin
                    pc_d = i_trap_target;
                end else if (i_fetch_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                        drain_d = 2'(FLUSH_CYCLES - 1);
                    end
                end
            end
            DRAIN: begin
                if (i_trap_valid) begin
                    state_d = REDIRECT;
                    pc_d    = i_trap_target;
                end else if (drain_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q    <= IDLE;
            pc_q       <= 32'd0;
            drain_q    <= 2'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drain_q    <= drain_d;
            misalign_q <= misalign_d;
        end
    end

    assign o_redirect_valid = (state_q == REDIRECT);
    assign o_redirect_pc    = pc_q;
    assign o_flush_if       = (state_q != IDLE);
    assign o_flush_id       = (state_q != IDLE);
    assign o_misalign_trap  = misalign_q;

`ifdef SPARROW_REDIRECT_PERF_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

    assign branch_cnt_d     = eval ? branch_cnt_q + 32'd1 : branch_cnt_q;
    assign mispredict_cnt_d = branch_redirect ? mispredict_cnt_q + 32'd1 : mispredict_cnt_q;

    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            branch_cnt_q     <= 32'd0;
            mispredict_cnt_q <= 32'd0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign o_branch_cnt     = branch_cnt_q;
    assign o_mispredict_cnt = mispredict_cnt_q;
`else
    assign o_branch_cnt     = 32'd0;
    assign o_mispredict_cnt = 32'd0;
`endif

endmodule
